// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
package sync_fifo_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_DEPTH    = 16;
   localparam int DEF_AE_LEVEL = 2;
   localparam int DEF_FWFT     = 0;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status signals between the FIFO and its user.
interface sync_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             we;
   logic [WIDTH-1:0] wdata;
   logic             re;
   logic [WIDTH-1:0] rdata;
   logic             rvalid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, we, wdata, re,
      input  rdata, rvalid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, we, wdata, re,
      output rdata, rvalid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO controller: pointers, occupancy count, flags and read port
// in either registered or first-word-fall-through mode.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = DEF_AE_LEVEL,
   parameter int FWFT     = DEF_FWFT
) (
   input  logic     clk,
   input  logic     rst_n,
   sync_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two in 2..256");
   end
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sync_fifo: WIDTH must be in 1..32");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo: FWFT must be 0 or 1");
   end

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             overflow_q;
   logic             underflow_q;
   logic             wr_ok;
   logic             rd_ok;
   logic [WIDTH-1:0] head;
   fifo_status_t     status;

   // Flags come only from the registered count, never from this cycle's we/re.
   assign status.full         = (count == DEPTH_C);
   assign status.empty        = (count == '0);
   assign status.almost_full  = (count >= AF_C);
   assign status.almost_empty = (count <= AE_C);
   assign status.overflow     = overflow_q;
   assign status.underflow    = underflow_q;

   assign wr_ok = bus.we && !status.full  && !bus.flush;
   assign rd_ok = bus.re && !status.empty && !bus.flush;

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (bus.wdata),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok && !rd_ok)      count <= count + CW'(1);
         else if (rd_ok && !wr_ok) count <= count - CW'(1);
         if (bus.we && status.full)  overflow_q  <= 1'b1;
         if (bus.re && status.empty) underflow_q <= 1'b1;
      end
   end

   if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else if (bus.flush) begin
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rd_ok;
            if (rd_ok) rdata_q <= head;
         end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
   end else begin : g_fwft_read
      assign bus.rdata  = head;
      assign bus.rvalid = !status.empty;
   end

   assign bus.full         = status.full;
   assign bus.empty        = status.empty;
   assign bus.almost_full  = status.almost_full;
   assign bus.almost_empty = status.almost_empty;
   assign bus.overflow     = status.overflow;
   assign bus.underflow    = status.underflow;
   assign bus.count        = count;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: three instances (depth 4 registered, depth 16 registered,
// depth 4 FWFT) share one stimulus stream and are compared to a queue model.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       we;
   logic       re;
   logic [7:0] wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_if #(.WIDTH(8), .DEPTH(4))  if_a ();
   sync_fifo_if #(.WIDTH(8), .DEPTH(16)) if_b ();
   sync_fifo_if #(.WIDTH(8), .DEPTH(4))  if_c ();

   assign if_a.flush = flush; assign if_a.we = we; assign if_a.re = re; assign if_a.wdata = wdata;
   assign if_b.flush = flush; assign if_b.we = we; assign if_b.re = re; assign if_b.wdata = wdata;
   assign if_c.flush = flush; assign if_c.we = we; assign if_c.re = re; assign if_c.wdata = wdata;

   sync_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
      u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   sync_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   // Model configuration per instance: depth, thresholds, read mode
   int dep [3] = '{4, 16, 4};
   int afl [3] = '{2, 14, 2};
   int ael [3] = '{2, 2, 2};
   int fw  [3] = '{0, 0, 1};

   logic [7:0] mq [3][$];
   bit         ovf      [3];
   bit         udf      [3];
   bit         rv_exp   [3];
   logic [7:0] rd_exp   [3];
   bit         rd_known [3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int sz;
         bit wr, rd;
         if (!rst_n) begin
            mq[i].delete();
            ovf[i] = 0; udf[i] = 0; rv_exp[i] = 0;
            rd_exp[i] = 8'h00; rd_known[i] = 1;
         end else if (flush) begin
            mq[i].delete();
            ovf[i] = 0; udf[i] = 0; rv_exp[i] = 0;
            rd_known[i] = 0;
         end else begin
            sz = mq[i].size();
            wr = we && (sz < dep[i]);
            rd = re && (sz > 0);
            rv_exp[i] = rd;
            if (rd) begin
               rd_exp[i]   = mq[i].pop_front();
               rd_known[i] = 1;
            end
            if (wr) mq[i].push_back(wdata);
            if (we && sz == dep[i]) ovf[i] = 1;
            if (re && sz == 0)      udf[i] = 1;
         end
      end
   end

   task automatic check_inst(input int i, input logic [31:0] cnt, input logic f, input logic e,
                             input logic af, input logic ae, input logic ov, input logic un,
                             input logic rv, input logic [7:0] rd);
      int sz;
      sz = mq[i].size();
      chk($sformatf("u%0d.count", i), cnt, sz);
      chk($sformatf("u%0d.full", i), f, sz == dep[i]);
      chk($sformatf("u%0d.empty", i), e, sz == 0);
      chk($sformatf("u%0d.almost_full", i), af, sz >= afl[i]);
      chk($sformatf("u%0d.almost_empty", i), ae, sz <= ael[i]);
      chk($sformatf("u%0d.overflow", i), ov, ovf[i]);
      chk($sformatf("u%0d.underflow", i), un, udf[i]);
      if (fw[i] == 0) begin
         chk($sformatf("u%0d.rvalid", i), rv, rv_exp[i]);
         if (rd_known[i]) chk($sformatf("u%0d.rdata", i), rd, rd_exp[i]);
      end else begin
         chk($sformatf("u%0d.rvalid", i), rv, sz != 0);
         if (sz != 0) chk($sformatf("u%0d.rdata", i), rd, mq[i][0]);
      end
   endtask

   always @(negedge clk) begin
      check_inst(0, if_a.count, if_a.full, if_a.empty, if_a.almost_full, if_a.almost_empty,
                 if_a.overflow, if_a.underflow, if_a.rvalid, if_a.rdata);
      check_inst(1, if_b.count, if_b.full, if_b.empty, if_b.almost_full, if_b.almost_empty,
                 if_b.overflow, if_b.underflow, if_b.rvalid, if_b.rdata);
      check_inst(2, if_c.count, if_c.full, if_c.empty, if_c.almost_full, if_c.almost_empty,
                 if_c.overflow, if_c.underflow, if_c.rvalid, if_c.rdata);
   end

   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic rn);
      we = w; wdata = d; re = r; flush = f; rst_n = rn;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      rst_n = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; wdata = 8'h00;
      cyc(0, 8'h00, 0, 0, 0);
      cyc(1, 8'hEE, 1, 0, 0);
      chk("reset.a_empty", if_a.empty, 1);
      chk("reset.a_full", if_a.full, 0);
      chk("reset.a_count", if_a.count, 0);
      chk("reset.a_rdata", if_a.rdata, 8'h00);
      chk("reset.b_almost_empty", if_b.almost_empty, 1);
      chk("reset.b_almost_full", if_b.almost_full, 0);

      // Fill depth-4 FIFO, then overflow it
      for (int k = 0; k < 4; k++) cyc(1, exp4[k], 0, 0, 1);
      chk("fill.a_full", if_a.full, 1);
      chk("fill.a_count", if_a.count, 4);
      chk("fill.b_count", if_b.count, 4);
      chk("fill.c_head", if_c.rdata, 8'h11);
      cyc(1, 8'h55, 0, 0, 1);
      chk("ovf.a_overflow", if_a.overflow, 1);
      chk("ovf.a_count", if_a.count, 4);
      chk("ovf.b_overflow", if_b.overflow, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 8'h00, 1, 0, 1);
         chk("drain.a_rvalid", if_a.rvalid, 1);
         chk("drain.a_rdata", if_a.rdata, exp4[k]);
      end
      chk("drain.a_empty", if_a.empty, 1);

      // Read of empty with simultaneous write
      cyc(1, 8'hA5, 1, 0, 1);
      chk("udf.a_underflow", if_a.underflow, 1);
      chk("udf.a_count", if_a.count, 1);
      chk("udf.a_rvalid", if_a.rvalid, 0);
      cyc(0, 8'h00, 1, 0, 1);
      chk("udf.a_rdata", if_a.rdata, 8'hA5);

      cyc(0, 8'h00, 0, 1, 1);
      chk("flush.a_overflow", if_a.overflow, 0);
      chk("flush.a_underflow", if_a.underflow, 0);
      chk("flush.b_count", if_b.count, 0);

      // Full with simultaneous we/re, then steady half-full streaming across wrap
      for (int k = 1; k <= 4; k++) cyc(1, 8'(k), 0, 0, 1);
      cyc(1, 8'h05, 1, 0, 1);
      chk("fullrw.a_count", if_a.count, 3);
      chk("fullrw.a_overflow", if_a.overflow, 1);
      chk("fullrw.a_rdata", if_a.rdata, 8'h01);
      cyc(0, 8'h00, 1, 0, 1);
      chk("half.a_count", if_a.count, 2);
      for (int k = 0; k < 10; k++) cyc(1, 8'(8'h10 + k), 1, 0, 1);
      chk("stream.a_count", if_a.count, 2);
      chk("stream.a_rdata", if_a.rdata, 8'h17);
      chk("stream.c_head", if_c.rdata, 8'h18);

      // Threshold crossings on the depth-16 instance, then flush mid-fill
      cyc(0, 8'h00, 0, 1, 1);
      for (int n = 1; n <= 14; n++) begin
         cyc(1, 8'(n), 0, 0, 1);
         if (n == 2)  chk("thr.b_ae_at2", if_b.almost_empty, 1);
         if (n == 3)  chk("thr.b_ae_at3", if_b.almost_empty, 0);
         if (n == 13) chk("thr.b_af_at13", if_b.almost_full, 0);
         if (n == 14) chk("thr.b_af_at14", if_b.almost_full, 1);
      end
      chk("thr.a_overflow", if_a.overflow, 1);
      cyc(1, 8'h99, 1, 1, 1);
      chk("mflush.b_count", if_b.count, 0);
      chk("mflush.b_empty", if_b.empty, 1);
      chk("mflush.a_overflow", if_a.overflow, 0);

      // FWFT fall-through, then reset with entries present
      cyc(1, 8'h3C, 0, 0, 1);
      chk("fwft.c_rdata", if_c.rdata, 8'h3C);
      chk("fwft.c_rvalid", if_c.rvalid, 1);
      cyc(0, 8'h00, 0, 0, 1);
      chk("fwft.c_hold", if_c.rdata, 8'h3C);
      cyc(1, 8'h3D, 0, 0, 1);
      cyc(1, 8'h3E, 0, 0, 1);
      chk("fwft.c_count3", if_c.count, 3);
      cyc(1, 8'h77, 1, 0, 0);
      chk("rst.c_empty", if_c.empty, 1);
      chk("rst.c_count", if_c.count, 0);
      chk("rst.a_rdata", if_a.rdata, 8'h00);

      // Randomized traffic with occasional flush and reset
      for (int k = 0; k < 3000; k++) begin
         logic w, r, f, rn;
         w  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 50);
         f  = ($urandom_range(0, 63) == 0);
         rn = ($urandom_range(0, 255) != 0);
         cyc(w, 8'($urandom), r, f, rn);
      end
      cyc(0, 8'h00, 0, 0, 1);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, legal range 2..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  synchronous clear of contents and sticky flags.
REQ-009 we  input  1  write request.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 re  input  1  read request.
REQ-012 rdata  output  WIDTH  read data.
REQ-013 rvalid  output  1  rdata holds a newly read word (FWFT=0 only; tied equal to !empty when FWFT=1).
REQ-014 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Accepted write = we && !full && !flush; accepted read = re && !empty && !flush; all flags derive from registered count, never from same-cycle we/re.
REQ-018 Accepted write stores wdata at write pointer; pointer increments modulo DEPTH.
REQ-019 Accepted read advances read pointer modulo DEPTH.
REQ-020 count: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-021 full = (count == DEPTH); empty = (count == 0); almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL).
REQ-022 FWFT=0: rdata updates to head word on the cycle after an accepted read, rvalid pulses high that one cycle, rdata holds its value otherwise.
REQ-023 FWFT=1: rdata presents head word whenever !empty, combinationally from storage; accepted read exposes the next word in the following cycle.
REQ-024 Write to full FIFO: data dropped, state unchanged, overflow set and held.
REQ-025 Read of empty FIFO: state unchanged, rdata held, rvalid stays 0, underflow set and held; applies even if we is high in the same cycle (written word becomes readable next cycle).
REQ-026 Full FIFO with we and re same cycle: read accepted, write rejected, overflow set; count becomes DEPTH-1.
REQ-027 flush: pointers and count go to 0, overflow/underflow clear, rvalid 0; flush has priority over we/re in the same cycle; rdata contents unspecified after flush.
REQ-028 Pointer wrap: after DEPTH writes and DEPTH reads data order SHALL be preserved exactly (FIFO order across wrap).

Reset
REQ-029 While rst_n low at a clk edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_LEVEL cond. met at 0, disallowed by range), overflow=0, underflow=0, rvalid=0, rdata=0 (FWFT=0).
REQ-030 Reset asserted mid-operation discards all contents; we/re ignored while rst_n low.
REQ-031 Storage array is not reset.

Structure
REQ-032 Package sync_fifo_pkg holds default parameter constants and a typedef for the status bundle {full, empty, almost_full, almost_empty, overflow, underflow}.
REQ-033 Storage SHALL be a single sub-module sync_fifo_mem (1 write port, 1 read port, synchronous write, asynchronous read), controlled by sync_fifo.
REQ-034 Elaboration SHALL fail on non-power-of-two DEPTH or out-of-range thresholds.

Verification
REQ-035 WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 -> full=1 and count=4 after 4th write; read 4 -> data 0x11..0x44 in order, empty=1.
REQ-036 DEPTH=4 full, pulse we with 0x55 -> overflow=1, count stays 4; subsequent reads return 0x11..0x44, no 0x55.
REQ-037 Empty, re with we=1 wdata=0xA5 -> underflow=1, count=1; next cycle read returns 0xA5.
REQ-038 Full, we=re=1 -> count=3, overflow=1; count=2 half-full, we=re=1 for 10 cycles -> count stays 2, order preserved across wrap.
REQ-039 DEPTH=16, AF_LEVEL=14, AE_LEVEL=2: fill word by word -> almost_empty drops at count 3, almost_full rises at count 14; flush mid-fill -> count=0, empty=1, sticky flags cleared.
REQ-040 FWFT=1, write 0x3C into empty -> rdata=0x3C one cycle later with no re; rst_n low with 3 entries -> empty=1, count=0 next cycle.
